// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage RV32 core.
// Produces the hold (bubble) and clear (flush) controls for the PC register
// and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It resolves
// data-cache miss stalls, control-flow redirects and load-use hazards. It also
// tracks miss episodes with a small FSM and keeps 32-bit performance counters.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   reg1_srcD, reg2_srcD       rs1/rs2 indices of the instruction in ID
//   reg_dstE, mem_readE        rd index / load flag of the instruction in EX
//   br_takenE, jalrE           EX-stage redirects (taken branch, JALR)
//   jalD                       JAL decoded in ID
//   missM                      data cache miss/busy for the access in MEM (level)
//   bubble*/flush*             per-stage hold/clear controls (combinational)
//   stall_cnt                  cycles with bubbleF=1
//   redirect_cnt               cycles with a control redirect applied
//   miss_cnt                   miss episodes (IDLE->MISS transitions)
module hazard_ctrl (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4:0]              reg1_srcD,
   input  logic [4:0]              reg2_srcD,
   input  logic [4:0]              reg_dstE,
   input  logic                    mem_readE,
   input  logic                    br_takenE,
   input  logic                    jalrE,
   input  logic                    jalD,
   input  logic                    missM,
   output logic                    bubbleF,
   output logic                    flushF,
   output logic                    bubbleD,
   output logic                    flushD,
   output logic                    bubbleE,
   output logic                    flushE,
   output logic                    bubbleM,
   output logic                    flushM,
   output logic                    bubbleW,
   output logic                    flushW,
   output logic [31:0]             stall_cnt,
   output logic [31:0]             redirect_cnt,
   output logic [31:0]             miss_cnt
);

   localparam int unsigned CNT_W = 32;

   typedef enum logic {
      IDLE = 1'b0,
      MISS = 1'b1
   } state_t;

   state_t state;
   state_t state_next;

   logic ex_redirect;
   logic load_use;
   logic miss_start;

   // Hazard detection terms
   assign ex_redirect = br_takenE | jalrE;
   assign load_use    = mem_readE && (reg_dstE != 5'd0) &&
                        ((reg_dstE == reg1_srcD) || (reg_dstE == reg2_srcD));
   assign miss_start  = (state == IDLE) && missM;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: one episode per IDLE->MISS entry
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (missM)  state_next = MISS;
         MISS:    if (!missM) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Control outputs, priority: reset > miss > EX redirect > load-use > JAL in ID.
   // Load-use outranks a lone JAL in ID: the JAL re-issues after the bubble.
   always_comb begin
      bubbleF = 1'b0;
      flushF  = 1'b0;
      bubbleD = 1'b0;
      flushD  = 1'b0;
      bubbleE = 1'b0;
      flushE  = 1'b0;
      bubbleM = 1'b0;
      flushM  = 1'b0;
      bubbleW = 1'b0;
      flushW  = 1'b0;
      if (rst) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
         flushW = 1'b1;
      end else if (missM) begin
         // Freeze everything up to EX/MEM, drain a bubble into WB
         bubbleF = 1'b1;
         bubbleD = 1'b1;
         bubbleE = 1'b1;
         bubbleM = 1'b1;
         flushW  = 1'b1;
      end else if (ex_redirect) begin
         flushD = 1'b1;
         flushE = 1'b1;
      end else if (load_use) begin
         bubbleF = 1'b1;
         bubbleD = 1'b1;
         flushE  = 1'b1;
      end else if (jalD) begin
         flushD = 1'b1;
      end
   end

   // Performance counters, wrapping modulo 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt    <= '0;
         redirect_cnt <= '0;
         miss_cnt     <= '0;
      end else begin
         if (bubbleF) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flushD && !missM) begin
            redirect_cnt <= redirect_cnt + CNT_W'(1);
         end
         if (miss_start) begin
            miss_cnt <= miss_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// Inputs change just after the falling edge; combinational controls are
// checked 1 time unit later and counters are checked on the following
// falling edge, after the rising edge that updates them.
module tb_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  reg1_srcD;
   logic [4:0]  reg2_srcD;
   logic [4:0]  reg_dstE;
   logic        mem_readE;
   logic        br_takenE;
   logic        jalrE;
   logic        jalD;
   logic        missM;
   logic        bubbleF, flushF, bubbleD, flushD, bubbleE, flushE;
   logic        bubbleM, flushM, bubbleW, flushW;
   logic [31:0] stall_cnt;
   logic [31:0] redirect_cnt;
   logic [31:0] miss_cnt;

   logic [9:0]  ctrl;
   int          checks;
   int          failures;
   logic [31:0] exp_stall;
   logic [31:0] exp_redir;
   logic [31:0] exp_miss;

   // Control patterns, ordered {bF,fF,bD,fD,bE,fE,bM,fM,bW,fW}
   localparam logic [9:0] P_NONE  = 10'b00_00_00_00_00;
   localparam logic [9:0] P_RESET = 10'b00_01_01_01_01;
   localparam logic [9:0] P_MISS  = 10'b10_10_10_10_01;
   localparam logic [9:0] P_EXRED = 10'b00_01_01_00_00;
   localparam logic [9:0] P_JAL   = 10'b00_01_00_00_00;
   localparam logic [9:0] P_LU    = 10'b10_10_01_00_00;

   assign ctrl = {bubbleF, flushF, bubbleD, flushD, bubbleE, flushE,
                  bubbleM, flushM, bubbleW, flushW};

   hazard_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .reg1_srcD    (reg1_srcD),
      .reg2_srcD    (reg2_srcD),
      .reg_dstE     (reg_dstE),
      .mem_readE    (mem_readE),
      .br_takenE    (br_takenE),
      .jalrE        (jalrE),
      .jalD         (jalD),
      .missM        (missM),
      .bubbleF      (bubbleF),
      .flushF       (flushF),
      .bubbleD      (bubbleD),
      .flushD       (flushD),
      .bubbleE      (bubbleE),
      .flushE       (flushE),
      .bubbleM      (bubbleM),
      .flushM       (flushM),
      .bubbleW      (bubbleW),
      .flushW       (flushW),
      .stall_cnt    (stall_cnt),
      .redirect_cnt (redirect_cnt),
      .miss_cnt     (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      reg1_srcD = 5'd0;
      reg2_srcD = 5'd0;
      reg_dstE  = 5'd0;
      mem_readE = 1'b0;
      br_takenE = 1'b0;
      jalrE     = 1'b0;
      jalD      = 1'b0;
      missM     = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      exp_stall = 32'd0;
      exp_redir = 32'd0;
      exp_miss  = 32'd0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst   = 1'b1;
      missM = 1'b1;
      #1;
      checks++;
      if (ctrl !== P_RESET) begin
         failures++;
         $display("FAIL reset_ctrl_c1: got %b expected %b", ctrl, P_RESET);
      end
      next_cycle();
      #1;
      checks++;
      if (ctrl !== P_RESET) begin
         failures++;
         $display("FAIL reset_ctrl_c2: got %b expected %b", ctrl, P_RESET);
      end
      next_cycle();
      rst = 1'b0;
      #1;
      checks++;
      if (stall_cnt !== 32'd0 || redirect_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
         failures++;
         $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
                  stall_cnt, redirect_cnt, miss_cnt);
      end
      checks++;
      if (ctrl !== P_MISS) begin
         failures++;
         $display("FAIL reset_then_miss_ctrl: got %b expected %b", ctrl, P_MISS);
      end
      next_cycle();
      checks++;
      if (miss_cnt !== 32'd1 || stall_cnt !== 32'd1) begin
         failures++;
         $display("FAIL reset_new_episode: miss=%0d stall=%0d expected 1/1",
                  miss_cnt, stall_cnt);
      end
      missM = 1'b0;
      next_cycle();
      exp_stall = 32'd1;
      exp_redir = 32'd0;
      exp_miss  = 32'd1;
   endtask

   task automatic test_load_use();
      clear_inputs();
      mem_readE = 1'b1;
      reg_dstE  = 5'd5;
      reg1_srcD = 5'd3;
      reg2_srcD = 5'd5;
      #1;
      checks++;
      if (ctrl !== P_LU) begin
         failures++;
         $display("FAIL load_use_rs2: got %b expected %b", ctrl, P_LU);
      end
      next_cycle();
      exp_stall = exp_stall + 32'd1;
      // Load moved on: no more hazard
      clear_inputs();
      #1;
      checks++;
      if (stall_cnt !== exp_stall || ctrl !== P_NONE) begin
         failures++;
         $display("FAIL load_use_count: stall=%0d ctrl=%b expected %0d/%b",
                  stall_cnt, ctrl, exp_stall, P_NONE);
      end
      mem_readE = 1'b1;
      reg_dstE  = 5'd0;
      reg1_srcD = 5'd0;
      reg2_srcD = 5'd0;
      #1;
      checks++;
      if (ctrl !== P_NONE) begin
         failures++;
         $display("FAIL load_use_x0: got %b expected %b", ctrl, P_NONE);
      end
      next_cycle();
      reg_dstE  = 5'd7;
      reg1_srcD = 5'd7;
      reg2_srcD = 5'd1;
      #1;
      checks++;
      if (ctrl !== P_LU) begin
         failures++;
         $display("FAIL load_use_rs1: got %b expected %b", ctrl, P_LU);
      end
      next_cycle();
      exp_stall = exp_stall + 32'd1;
      mem_readE = 1'b0;
      #1;
      checks++;
      if (ctrl !== P_NONE) begin
         failures++;
         $display("FAIL no_load_match: got %b expected %b", ctrl, P_NONE);
      end
      next_cycle();
      checks++;
      if (stall_cnt !== exp_stall) begin
         failures++;
         $display("FAIL load_use_total: got %0d expected %0d", stall_cnt, exp_stall);
      end
   endtask

   task automatic test_redirect();
      clear_inputs();
      br_takenE = 1'b1;
      jalD      = 1'b1;
      #1;
      checks++;
      if (ctrl !== P_EXRED) begin
         failures++;
         $display("FAIL br_and_jal: got %b expected %b", ctrl, P_EXRED);
      end
      next_cycle();
      exp_redir = exp_redir + 32'd1;
      checks++;
      if (redirect_cnt !== exp_redir) begin
         failures++;
         $display("FAIL redirect_cnt_br: got %0d expected %0d", redirect_cnt, exp_redir);
      end
      br_takenE = 1'b0;
      #1;
      checks++;
      if (ctrl !== P_JAL) begin
         failures++;
         $display("FAIL jal_only: got %b expected %b", ctrl, P_JAL);
      end
      next_cycle();
      exp_redir = exp_redir + 32'd1;
      jalD  = 1'b0;
      jalrE = 1'b1;
      #1;
      checks++;
      if (ctrl !== P_EXRED) begin
         failures++;
         $display("FAIL jalr: got %b expected %b", ctrl, P_EXRED);
      end
      next_cycle();
      exp_redir = exp_redir + 32'd1;
      // JAL in ID alongside a load-use: load-use wins, no redirect counted
      clear_inputs();
      jalD      = 1'b1;
      mem_readE = 1'b1;
      reg_dstE  = 5'd9;
      reg1_srcD = 5'd9;
      #1;
      checks++;
      if (ctrl !== P_LU) begin
         failures++;
         $display("FAIL jal_with_load_use: got %b expected %b", ctrl, P_LU);
      end
      next_cycle();
      exp_stall = exp_stall + 32'd1;
      clear_inputs();
      checks++;
      if (redirect_cnt !== exp_redir || stall_cnt !== exp_stall) begin
         failures++;
         $display("FAIL redirect_totals: redir=%0d stall=%0d expected %0d/%0d",
                  redirect_cnt, stall_cnt, exp_redir, exp_stall);
      end
   endtask

   task automatic test_overlap();
      do_reset();
      mem_readE = 1'b1;
      reg_dstE  = 5'd4;
      reg2_srcD = 5'd4;
      br_takenE = 1'b1;
      jalD      = 1'b1;
      missM     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ctrl !== P_MISS) begin
            failures++;
            $display("FAIL overlap_ctrl_%0d: got %b expected %b", i, ctrl, P_MISS);
         end
         next_cycle();
      end
      clear_inputs();
      next_cycle();
      checks++;
      if (stall_cnt !== 32'd3 || redirect_cnt !== 32'd0 || miss_cnt !== 32'd1) begin
         failures++;
         $display("FAIL overlap_counters: got %0d/%0d/%0d expected 3/0/1",
                  stall_cnt, redirect_cnt, miss_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] pattern;
      pattern = 4'b1011;
      do_reset();
      for (int i = 3; i >= 0; i--) begin
         missM = pattern[i];
         next_cycle();
      end
      missM = 1'b0;
      #1;
      checks++;
      if (ctrl !== P_NONE) begin
         failures++;
         $display("FAIL b2b_resume: got %b expected %b", ctrl, P_NONE);
      end
      next_cycle();
      checks++;
      if (miss_cnt !== 32'd2 || stall_cnt !== 32'd3) begin
         failures++;
         $display("FAIL b2b_counters: miss=%0d stall=%0d expected 2/3",
                  miss_cnt, stall_cnt);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      force dut.stall_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt;
      mem_readE = 1'b1;
      reg_dstE  = 5'd12;
      reg1_srcD = 5'd12;
      next_cycle();
      checks++;
      if (stall_cnt !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL wrap_pre: got %h expected ffffffff", stall_cnt);
      end
      next_cycle();
      clear_inputs();
      checks++;
      if (stall_cnt !== 32'h0000_0000) begin
         failures++;
         $display("FAIL wrap_zero: got %h expected 00000000", stall_cnt);
      end
      next_cycle();
      checks++;
      if (stall_cnt !== 32'h0000_0000) begin
         failures++;
         $display("FAIL wrap_hold: got %h expected 00000000", stall_cnt);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      exp_stall = 32'd0;
      exp_redir = 32'd0;
      exp_miss  = 32'd0;
      rst       = 1'b1;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_load_use();
      test_redirect();
      test_overlap();
      test_back_to_back();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
